mem_bus_unit: RTL and testbench
===============================

# mem_bus_unit

- Sits between the control sequencer's memory strobes and the external memory port.
- Latches the 16-bit address, sequences one read or write per memory window, and absorbs memory wait states.
- Raises `stall` while a transaction is outstanding.
- Read data is registered and driven onto the internal data bus for the remainder of the read window.

## Interface
- `ADDR_W`, 16, address width.
- `DATA_W`, 8, data width.
- `TIMEOUT`, 15, maximum wait cycles before abort (used only with watchdog compiled in).
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `addr_bus`  in  ADDR_W  address source, sampled on `address_read`.
- `address_read`  in  1  latch `addr_bus` into address register.
- `mem_enable`  in  1  memory window active.
- `data_in`  in  1  window direction: memory to bus (read).
- `data_out`  in  1  window direction: bus to memory (write).
- `bus_in`  in  DATA_W  internal data bus (write data).
- `bus_out`  out  DATA_W  registered read data.
- `bus_out_en`  out  1  `bus_out` is driving the internal bus.
- `stall`  out  1  transaction outstanding, memory not yet acknowledged.
- `error`  out  1  sticky protocol/timeout error.
- `ext_addr`  out  ADDR_W  memory address.
- `ext_wdata`  out  DATA_W  memory write data.
- `ext_we`  out  1  write strobe qualifier.
- `ext_req`  out  1  memory request.
- `ext_ack`  in  1  memory acknowledge; `ext_rdata` valid when high; may be high in the request cycle (zero wait).
- `ext_rdata`  in  DATA_W  memory read data.

## Operation
- States: IDLE, WAIT_RD, WAIT_WR, HOLD_RD.
- Request:
  - `req_rd = mem_enable & data_in & ~data_out`
  - `req_wr = mem_enable & data_out & ~data_in`
- IDLE:
  - `address_read` loads the address register.
  - `req_rd`/`req_wr` assert `ext_req` combinationally in the same cycle.
  - `req_wr` captures `bus_in` into the write-data register.
  - `ext_wdata` = `bus_in` in that cycle, the register value afterwards.
- IDLE transitions:
  - `req_rd` with `ext_ack`: capture `ext_rdata`, go to HOLD_RD.
  - `req_rd` without ack: go to WAIT_RD.
  - `req_wr` with `ext_ack`: stay IDLE.
  - `req_wr` without ack: go to WAIT_WR.
- WAIT_RD / WAIT_WR:
  - `ext_req` held high; `ext_addr`, `ext_we`, `ext_wdata` stable.
  - On `ext_ack`: read captures data, goes to HOLD_RD; write goes to IDLE.
- HOLD_RD:
  - `bus_out_en = req_rd`.
  - When `req_rd` drops, state becomes IDLE.
  - That same cycle is evaluated as IDLE: `address_read` and `req_wr` are honoured.
- `stall = ext_req & ~ext_ack`.
- `address_read` outside IDLE/HOLD_RD-exit is ignored.
- `mem_enable` with both or neither direction bit: no request, `error` set.
- `mem_enable` dropping during WAIT_*:
  - The external transaction still completes.
  - Read data is captured, but `bus_out_en` stays 0.
- `ext_ack` outside a request is ignored.

## Timing
- Reset (`rst_n`=0 at posedge):
  - state IDLE; address, `bus_out`, write-data register 0; `error` 0.
  - While `rst_n` is low: `ext_req`, `ext_we`, `bus_out_en`, `stall` forced 0.
  - Reset mid-transaction abandons it; memory must tolerate a dropped `ext_req`.
- Zero-wait read:
  - Request in cycle n; data registered at end of n; `bus_out_en` from cycle n+1.
  - This matches the sequencer's two-cycle read window.
- Each wait state adds one cycle; `stall` is high in every unacknowledged request cycle.
- Write latency: 1 cycle zero-wait, 1+k with k wait states.
- `ext_addr` always equals the address register (registered, glitch-free).

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined:
  - Watchdog counts cycles spent in WAIT_*.
  - On reaching `TIMEOUT`: abort to IDLE (read: go to HOLD_RD with `bus_out`=8'hFF), set `error`, drop `ext_req`.
  - Counter clears on entering WAIT_*.
- `MEM_BUS_TIMEOUT_EN` undefined: no counter; WAIT_* waits indefinitely; `TIMEOUT` unused.

## Structure
- Shared package:
  - `mem_bus_state_t` enum.
  - `MEMBUS_ERR_RDATA` = 8'hFF.
  - `MEMBUS_ADDR_W` / `MEMBUS_DATA_W` constants.
- Optional sub-module `mem_bus_watchdog`: counter with clear/enable/expired, instantiated only under `MEM_BUS_TIMEOUT_EN`.

## Test plan
- `address_read` with `addr_bus`=16'h1234, then 2-cycle read window, `ext_ack` same cycle with `ext_rdata`=8'hA5 -> `ext_addr`=16'h1234, `stall` never high, `bus_out`=8'hA5 with `bus_out_en` in cycle 2 only.
- Read with 3 wait states, `ext_rdata`=8'h3C -> `stall` high 3 cycles, `ext_req` high 4 cycles, `bus_out`=8'h3C after ack.
- Write with `bus_in`=8'h7E for one cycle, ack after 2 waits, `bus_in` changed to 8'h00 -> `ext_wdata` stays 8'h7E, `ext_we`=1 throughout, return to IDLE.
- `mem_enable` with `data_in`=`data_out`=1 -> no `ext_req`, `error`=1 and sticky until reset.
- `rst_n` low during WAIT_RD -> next cycle IDLE, `ext_req`=0, `bus_out`=0, `error`=0.
- With `MEM_BUS_TIMEOUT_EN`, `TIMEOUT`=15, no ack -> after 15 wait cycles `ext_req` drops, `bus_out`=8'hFF, `error`=1.

Source files
------------

// File: rtl/mem_bus_unit_pkg.sv
// mem_bus_unit_pkg
// Shared types and constants for the memory bus unit.
//   mem_bus_state_t  : transaction FSM states
//   MEMBUS_ADDR_W    : default address width
//   MEMBUS_DATA_W    : default data width
//   MEMBUS_ERR_RDATA : read data returned when a read is aborted by the watchdog
package mem_bus_unit_pkg;

  localparam int MEMBUS_ADDR_W = 16;
  localparam int MEMBUS_DATA_W = 8;

  localparam logic [MEMBUS_DATA_W-1:0] MEMBUS_ERR_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    WAIT_WR = 2'd2,
    HOLD_RD = 2'd3
  } mem_bus_state_t;

endpackage

// File: rtl/mem_bus_watchdog.sv
// mem_bus_watchdog
// Wait-state watchdog used when MEM_BUS_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : zero the counter (transaction entering a wait state)
//   en          : count this cycle (transaction is waiting)
//   expired     : this is the TIMEOUT-th waiting cycle; abort at its end
module mem_bus_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter is 0 in the first wait cycle, so it reads TIMEOUT-1 in the last.
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_bus_unit.sv
// mem_bus_unit
// Bridges the control sequencer's memory strobes to the external memory port:
// latches the address, runs one read or write per memory window, absorbs
// wait states and holds read data on the internal bus for the rest of the
// read window.
// Optional build macro: MEM_BUS_TIMEOUT_EN (wait-state watchdog, aborts after
// TIMEOUT wait cycles with error set and read data MEMBUS_ERR_RDATA).
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   addr_bus, address_read  : address source and its load strobe
//   mem_enable, data_in,
//   data_out                : memory window and its direction (read / write)
//   bus_in                  : write data from the internal bus
//   bus_out, bus_out_en     : registered read data and its bus drive enable
//   stall                   : request outstanding and not acknowledged
//   error                   : sticky direction/timeout error
//   ext_addr, ext_wdata,
//   ext_we, ext_req         : external memory request
//   ext_ack, ext_rdata      : external memory acknowledge and read data
module mem_bus_unit
  import mem_bus_unit_pkg::*;
#(
  parameter int          ADDR_W  = MEMBUS_ADDR_W,
  parameter int          DATA_W  = MEMBUS_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              address_read,
  input  logic              mem_enable,
  input  logic              data_in,
  input  logic              data_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_out_en,
  output logic              stall,
  output logic              error,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  output logic              ext_we,
  output logic              ext_req,
  input  logic              ext_ack,
  input  logic [DATA_W-1:0] ext_rdata
);

  mem_bus_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic req_rd, req_wr, bad_dir;
  logic st_idle, in_wait;
  logic wd_clr, wd_expired;

  assign req_rd  = mem_enable & data_in & ~data_out;
  assign req_wr  = mem_enable & data_out & ~data_in;
  assign bad_dir = mem_enable & (data_in == data_out);

  // The cycle that closes a read hold behaves as IDLE so the sequencer can
  // load a new address or start a write without a dead cycle.
  assign st_idle = (state_q == IDLE) || (state_q == HOLD_RD && !req_rd);
  assign in_wait = (state_q == WAIT_RD) || (state_q == WAIT_WR);

`ifdef MEM_BUS_TIMEOUT_EN
  mem_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (in_wait),
    .expired (wd_expired)
  );
`else
  logic unused_wdog;
  assign wd_expired  = 1'b0;
  assign unused_wdog = |{TIMEOUT, wd_clr};
`endif

  // Next state and datapath registers
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q | bad_dir;
    wd_clr  = 1'b0;

    case (state_q)
      WAIT_RD: begin
        if (ext_ack) begin
          rdata_d = ext_rdata;
          state_d = HOLD_RD;
        end else if (wd_expired) begin
          rdata_d = DATA_W'(MEMBUS_ERR_RDATA);
          err_d   = 1'b1;
          state_d = HOLD_RD;
        end
      end
      WAIT_WR: begin
        if (ext_ack) begin
          state_d = IDLE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (st_idle) begin
      if (address_read) addr_d = addr_bus;
      if (req_rd) begin
        if (ext_ack) begin
          rdata_d = ext_rdata;
          state_d = HOLD_RD;
        end else begin
          state_d = WAIT_RD;
          wd_clr  = 1'b1;
        end
      end else if (req_wr) begin
        wdata_d = bus_in;
        if (ext_ack) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_WR;
          wd_clr  = 1'b1;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs; strobes are gated by rst_n so a reset drops them immediately.
  always_comb begin
    ext_req    = 1'b0;
    ext_we     = 1'b0;
    ext_wdata  = wdata_q;
    bus_out_en = 1'b0;
    if (rst_n) begin
      ext_req    = in_wait || (st_idle && (req_rd || req_wr));
      ext_we     = (state_q == WAIT_WR) || (st_idle && req_wr);
      bus_out_en = (state_q == HOLD_RD) && req_rd;
    end
    // Write data is passed straight through in the request cycle.
    if (st_idle && req_wr) ext_wdata = bus_in;
  end

  assign stall    = ext_req & ~ext_ack;
  assign ext_addr = addr_q;
  assign bus_out  = rdata_q;
  assign error    = err_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
module tb_mem_bus_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr_bus;
  logic        address_read;
  logic        mem_enable;
  logic        data_in;
  logic        data_out;
  logic [7:0]  bus_in;
  logic [7:0]  bus_out;
  logic        bus_out_en;
  logic        stall;
  logic        error;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_we;
  logic        ext_req;
  logic        ext_ack;
  logic [7:0]  ext_rdata;

  int checks = 0;
  int errors = 0;

  mem_bus_unit #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_bus     (addr_bus),
    .address_read (address_read),
    .mem_enable   (mem_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .bus_out_en   (bus_out_en),
    .stall        (stall),
    .error        (error),
    .ext_addr     (ext_addr),
    .ext_wdata    (ext_wdata),
    .ext_we       (ext_we),
    .ext_req      (ext_req),
    .ext_ack      (ext_ack),
    .ext_rdata    (ext_rdata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    address_read = 1'b0;
    mem_enable   = 1'b0;
    data_in      = 1'b0;
    data_out     = 1'b0;
    ext_ack      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addr_bus = 16'h0; bus_in = 8'h0; ext_rdata = 8'h0;
    idle_inputs();
    cyc(); cyc();
    // request inputs while reset is held must not reach the memory
    mem_enable = 1'b1; data_out = 1'b1; #1;
    checks++; if (ext_req !== 1'b0 || ext_we !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: req=%b we=%b stall=%b, want 0 0 0", ext_req, ext_we, stall); end
    cyc();
    idle_inputs(); rst_n = 1'b1; #1;
    checks++; if (ext_addr !== 16'h0 || bus_out !== 8'h0 || error !== 1'b0 || bus_out_en !== 1'b0) begin
      errors++; $display("FAIL reset_state: addr=%h bus_out=%h err=%b en=%b, want 0", ext_addr, bus_out, error, bus_out_en); end
  endtask

  task automatic test_zero_wait_read();
    int stalls = 0;
    address_read = 1'b1; addr_bus = 16'h1234;
    cyc();
    address_read = 1'b0; #1;
    checks++; if (ext_addr !== 16'h1234) begin
      errors++; $display("FAIL zr_addr: got %h want 1234", ext_addr); end
    // cycle 1 of window: ack same cycle
    mem_enable = 1'b1; data_in = 1'b1; ext_ack = 1'b1; ext_rdata = 8'hA5; #1;
    if (stall) stalls++;
    checks++; if (ext_req !== 1'b1 || ext_we !== 1'b0 || bus_out_en !== 1'b0) begin
      errors++; $display("FAIL zr_c1: req=%b we=%b en=%b want 1 0 0", ext_req, ext_we, bus_out_en); end
    cyc();
    // cycle 2 of window: stray ack is ignored
    ext_ack = 1'b1; ext_rdata = 8'h11; #1;
    if (stall) stalls++;
    checks++; if (bus_out !== 8'hA5 || bus_out_en !== 1'b1 || ext_req !== 1'b0) begin
      errors++; $display("FAIL zr_c2: bus_out=%h en=%b req=%b want a5 1 0", bus_out, bus_out_en, ext_req); end
    cyc();
    idle_inputs(); #1;
    if (stall) stalls++;
    checks++; if (bus_out_en !== 1'b0 || ext_req !== 1'b0 || bus_out !== 8'hA5) begin
      errors++; $display("FAIL zr_end: en=%b req=%b bus_out=%h want 0 0 a5", bus_out_en, ext_req, bus_out); end
    checks++; if (stalls !== 0) begin
      errors++; $display("FAIL zr_stall: stall cycles %0d want 0", stalls); end
    cyc();
  endtask

  task automatic test_wait_read();
    int stalls = 0;
    int reqs = 0;
    mem_enable = 1'b1; data_in = 1'b1; ext_rdata = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      ext_ack = (i == 3);
      address_read = (i == 1); addr_bus = 16'h9999;
      #1;
      if (stall) stalls++;
      if (ext_req) reqs++;
      checks++; if (ext_addr !== 16'h1234) begin
        errors++; $display("FAIL wr_addr_stable: cycle %0d addr=%h want 1234", i, ext_addr); end
      cyc();
    end
    address_read = 1'b0; ext_ack = 1'b0; #1;
    checks++; if (stalls !== 3 || reqs !== 4) begin
      errors++; $display("FAIL wr_counts: stall=%0d req=%0d want 3 4", stalls, reqs); end
    checks++; if (bus_out !== 8'h3C || bus_out_en !== 1'b1 || ext_req !== 1'b0) begin
      errors++; $display("FAIL wr_data: bus_out=%h en=%b req=%b want 3c 1 0", bus_out, bus_out_en, ext_req); end
    checks++; if (ext_addr !== 16'h1234) begin
      errors++; $display("FAIL wr_addr_ignored: addr=%h want 1234", ext_addr); end
    cyc();
    idle_inputs(); cyc();
  endtask

  task automatic test_write_wait();
    mem_enable = 1'b1; data_out = 1'b1; bus_in = 8'h7E; #1;
    checks++; if (ext_req !== 1'b1 || ext_we !== 1'b1 || ext_wdata !== 8'h7E || stall !== 1'b1) begin
      errors++; $display("FAIL ww_c0: req=%b we=%b wd=%h stall=%b want 1 1 7e 1", ext_req, ext_we, ext_wdata, stall); end
    cyc();
    bus_in = 8'h00; #1;
    checks++; if (ext_req !== 1'b1 || ext_we !== 1'b1 || ext_wdata !== 8'h7E || stall !== 1'b1) begin
      errors++; $display("FAIL ww_c1: req=%b we=%b wd=%h stall=%b want 1 1 7e 1", ext_req, ext_we, ext_wdata, stall); end
    cyc();
    ext_ack = 1'b1; #1;
    checks++; if (ext_req !== 1'b1 || ext_we !== 1'b1 || ext_wdata !== 8'h7E || stall !== 1'b0) begin
      errors++; $display("FAIL ww_ack: req=%b we=%b wd=%h stall=%b want 1 1 7e 0", ext_req, ext_we, ext_wdata, stall); end
    cyc();
    idle_inputs(); #1;
    checks++; if (ext_req !== 1'b0 || ext_we !== 1'b0 || ext_wdata !== 8'h7E) begin
      errors++; $display("FAIL ww_idle: req=%b we=%b wd=%h want 0 0 7e", ext_req, ext_we, ext_wdata); end
    cyc();
  endtask

  task automatic test_zero_wait_write();
    mem_enable = 1'b1; data_out = 1'b1; bus_in = 8'h55; ext_ack = 1'b1; #1;
    checks++; if (ext_req !== 1'b1 || stall !== 1'b0 || ext_wdata !== 8'h55) begin
      errors++; $display("FAIL zw: req=%b stall=%b wd=%h want 1 0 55", ext_req, stall, ext_wdata); end
    cyc();
    idle_inputs(); bus_in = 8'h00; #1;
    checks++; if (ext_req !== 1'b0 || ext_wdata !== 8'h55) begin
      errors++; $display("FAIL zw_after: req=%b wd=%h want 0 55", ext_req, ext_wdata); end
    cyc();
  endtask

  task automatic test_enable_drop();
    mem_enable = 1'b1; data_in = 1'b1; ext_rdata = 8'h00;
    cyc();
    idle_inputs(); ext_ack = 1'b1; ext_rdata = 8'hC3; #1;
    checks++; if (ext_req !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL ed_held: req=%b stall=%b want 1 0", ext_req, stall); end
    cyc();
    ext_ack = 1'b0; #1;
    checks++; if (bus_out !== 8'hC3 || bus_out_en !== 1'b0 || ext_req !== 1'b0) begin
      errors++; $display("FAIL ed_capture: bus_out=%h en=%b req=%b want c3 0 0", bus_out, bus_out_en, ext_req); end
    cyc();
  endtask

  task automatic test_hold_exit();
    address_read = 1'b1; addr_bus = 16'h1234; cyc(); address_read = 1'b0;
    mem_enable = 1'b1; data_in = 1'b1; ext_ack = 1'b1; ext_rdata = 8'h5A;
    cyc();
    // still inside the read window: address load ignored
    ext_ack = 1'b0; address_read = 1'b1; addr_bus = 16'hBEEF;
    cyc();
    checks++; if (ext_addr !== 16'h1234 || bus_out_en !== 1'b1) begin
      errors++; $display("FAIL he_ignored: addr=%h en=%b want 1234 1", ext_addr, bus_out_en); end
    // window closes: same cycle honours the address load
    mem_enable = 1'b0; data_in = 1'b0; addr_bus = 16'hCAFE;
    cyc();
    address_read = 1'b0; #1;
    checks++; if (ext_addr !== 16'hCAFE || bus_out_en !== 1'b0) begin
      errors++; $display("FAIL he_load: addr=%h en=%b want cafe 0", ext_addr, bus_out_en); end
    cyc();
  endtask

  task automatic test_error();
    mem_enable = 1'b1; data_in = 1'b1; data_out = 1'b1; #1;
    checks++; if (ext_req !== 1'b0) begin
      errors++; $display("FAIL err_noreq: req=%b want 0", ext_req); end
    cyc();
    idle_inputs(); cyc(); cyc();
    checks++; if (error !== 1'b1) begin
      errors++; $display("FAIL err_sticky: error=%b want 1", error); end
  endtask

  task automatic test_reset_mid();
    mem_enable = 1'b1; data_in = 1'b1;
    cyc();
    rst_n = 1'b0; #1;
    checks++; if (ext_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rm_forced: req=%b stall=%b want 0 0", ext_req, stall); end
    cyc();
    rst_n = 1'b1; idle_inputs(); #1;
    checks++; if (ext_req !== 1'b0 || bus_out !== 8'h00 || error !== 1'b0 || ext_addr !== 16'h0) begin
      errors++; $display("FAIL rm_state: req=%b bus_out=%h err=%b addr=%h want 0 00 0 0000", ext_req, bus_out, error, ext_addr); end
    cyc();
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int reqs = 0;
    mem_enable = 1'b1; data_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ext_req) reqs++;
      cyc();
    end
    checks++; if (reqs !== 16 || bus_out !== 8'hFF || error !== 1'b1) begin
      errors++; $display("FAIL timeout: req cycles=%0d bus_out=%h err=%b want 16 ff 1", reqs, bus_out, error); end
    idle_inputs(); cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_read();
    test_write_wait();
    test_zero_wait_write();
    test_enable_drop();
    test_hold_exit();
    test_error();
    test_reset_mid();
`ifdef MEM_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
